// File: rtl/ascii_pkg.sv
// Shared character constants and parser state encoding for the ASCII hex line parser.
package ascii_pkg;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_UA = 8'h41;
    localparam logic [7:0] CH_UF = 8'h46;
    localparam logic [7:0] CH_LA = 8'h61;
    localparam logic [7:0] CH_LF_HEX = 8'h66;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_SKIP  = 2'd3;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational byte classifier: hex digit (with nibble value) or line terminator.
module ascii_hex_decode
    import ascii_pkg::*;
(
    input  logic [7:0] din,
    output logic       is_digit,
    output logic       is_term,
    output logic [3:0] nibble
);

    logic w_num;
    logic w_alpha;

    assign w_num    = (din >= CH_0)  && (din <= CH_9);
    assign w_alpha  = ((din >= CH_UA) && (din <= CH_UF)) ||
                      ((din >= CH_LA) && (din <= CH_LF_HEX));
    assign is_digit = w_num || w_alpha;
    assign is_term  = (din == CH_CR) || (din == CH_LF);
    // Letters A-F/a-f have low nibble 1..6, so +9 maps them onto 10..15.
    assign nibble   = din[3:0] + (w_alpha ? 4'd9 : 4'd0);

endmodule

// File: rtl/ascii_hex_parser.sv
// Line-oriented ASCII hex parser: accumulates up to NDIG digits per line and
// presents the value with a valid/ready handshake; malformed lines are skipped.
module ascii_hex_parser
    import ascii_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int VW   = 4 * NDIG
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_done_tick,
    input  logic [7:0]    din,
    output logic [VW-1:0] value,
    output logic          value_valid,
    input  logic          value_ready,
    output logic          err_tick,
    output logic          overrun_tick
);

    localparam int CW = $clog2(NDIG + 1);

    logic          w_is_digit;
    logic          w_is_term;
    logic [3:0]    w_nibble;

    logic [1:0]    r_state;
    logic [VW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [VW-1:0] r_value;
    logic          r_value_valid;
    logic          r_err;
    logic          r_ovr;

    logic [1:0]    w_state_nx;
    logic [VW-1:0] w_acc_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [VW-1:0] w_value_nx;
    logic          w_err_nx;
    logic          w_ovr_nx;
    logic          w_hs;
    logic [1:0]    w_cur;

    ascii_hex_decode u_dec (
        .din      (din),
        .is_digit (w_is_digit),
        .is_term  (w_is_term),
        .nibble   (w_nibble)
    );

    // A completing handshake frees the parser in the same cycle, so a byte
    // arriving alongside it is handled from IDLE.
    assign w_hs  = r_value_valid && value_ready;
    assign w_cur = w_hs ? S_IDLE : r_state;

    always_comb begin
        w_state_nx = w_cur;
        w_acc_nx   = r_acc;
        w_cnt_nx   = r_cnt;
        w_value_nx = r_value;
        w_err_nx   = 1'b0;
        w_ovr_nx   = 1'b0;
        if (rx_done_tick) begin
            case (w_cur)
                S_IDLE: begin
                    if (w_is_digit) begin
                        w_acc_nx   = VW'(w_nibble);
                        w_cnt_nx   = CW'(1);
                        w_state_nx = S_ACCUM;
                    end else if (!w_is_term) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = S_SKIP;
                    end
                end
                S_ACCUM: begin
                    if (w_is_digit && (r_cnt != CW'(NDIG))) begin
                        w_acc_nx = {r_acc[VW-5:0], w_nibble};
                        w_cnt_nx = r_cnt + CW'(1);
                    end else if (w_is_term) begin
                        w_value_nx = r_acc;
                        w_acc_nx   = '0;
                        w_cnt_nx   = '0;
                        w_state_nx = S_HOLD;
                    end else begin
                        w_err_nx   = 1'b1;
                        w_acc_nx   = '0;
                        w_cnt_nx   = '0;
                        w_state_nx = S_SKIP;
                    end
                end
                S_SKIP: begin
                    if (w_is_term) w_state_nx = S_IDLE;
                end
                default: w_ovr_nx = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_err         <= 1'b0;
            r_ovr         <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_acc         <= w_acc_nx;
            r_cnt         <= w_cnt_nx;
            r_value       <= w_value_nx;
            r_value_valid <= (w_state_nx == S_HOLD);
            r_err         <= w_err_nx;
            r_ovr         <= w_ovr_nx;
        end
    end

    assign value        = r_value;
    assign value_valid  = r_value_valid;
    assign err_tick     = r_err;
    assign overrun_tick = r_ovr;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Scoreboard bench for ascii_hex_parser: a line-level reference model predicts
// values, error and overrun pulses; a negedge monitor checks what the DUT emits.
module tb_ascii_hex_parser;

    localparam int NDIG = 4;
    localparam int VW   = 4 * NDIG;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_done_tick = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          value_ready = 1'b0;
    logic [VW-1:0] value;
    logic          value_valid;
    logic          err_tick;
    logic          overrun_tick;

    ascii_hex_parser #(.NDIG(NDIG), .VW(VW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_done_tick (rx_done_tick),
        .din          (din),
        .value        (value),
        .value_valid  (value_valid),
        .value_ready  (value_ready),
        .err_tick     (err_tick),
        .overrun_tick (overrun_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [VW-1:0] v;
        int            c;
    } exp_t;

    exp_t val_q[$];
    int   err_q[$];
    int   ovr_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: a line is a list of nibbles; any bad byte poisons the line.
    int dig_q[$];
    bit m_bad  = 0;
    bit m_hold = 0;

    task automatic step(input bit t, input logic [7:0] b, input bit r);
        bit hs;
        bit isdig;
        int nib;
        exp_t e;
        hs = m_hold && r;
        if (m_hold && !hs) begin
            if (t) ovr_q.push_back(cyc + 1);
            return;
        end
        m_hold = 0;
        if (!t) return;
        isdig = 1; nib = 0;
        if (b >= "0" && b <= "9")      nib = int'(b) - 48;
        else if (b >= "A" && b <= "F") nib = int'(b) - 55;
        else if (b >= "a" && b <= "f") nib = int'(b) - 87;
        else isdig = 0;
        if (b == 8'h0D || b == 8'h0A) begin
            if (!m_bad && dig_q.size() > 0) begin
                e.v = '0;
                foreach (dig_q[i]) e.v = e.v * 16 + VW'(dig_q[i]);
                e.c = cyc + 1;
                val_q.push_back(e);
                m_hold = 1;
            end
            dig_q.delete();
            m_bad = 0;
        end else if (!m_bad) begin
            if (!isdig || dig_q.size() == NDIG) begin
                err_q.push_back(cyc + 1);
                m_bad = 1;
                dig_q.delete();
            end else begin
                dig_q.push_back(nib);
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input bit r);
        @(posedge clk); #1;
        rx_done_tick = 1'b1; din = b; value_ready = r;
        step(1, b, r);
    endtask

    task automatic idle(input bit r);
        @(posedge clk); #1;
        rx_done_tick = 1'b0; value_ready = r;
        step(0, 8'h00, r);
    endtask

    task automatic send_str(input string s, input bit r);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], r);
            idle(r);
        end
    endtask

    task automatic line(input string s, input bit r);
        send_str(s, r);
        send(8'h0D, r);
        idle(r); idle(r); idle(r);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_value"}, value, 0);
        chk({name, "_valid"}, value_valid, 0);
        chk({name, "_err"}, err_tick, 0);
        chk({name, "_ovr"}, overrun_tick, 0);
    endtask

    // Monitor
    bit prev_valid = 0;
    bit prev_ready = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_tick) begin
                if (err_q.size() == 0) chk("err_unexpected", err_q.size(), 1);
                else chk("err_time", cyc, err_q.pop_front());
            end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
                chk("err_missing", err_tick, 1);
                void'(err_q.pop_front());
            end
            if (overrun_tick) begin
                if (ovr_q.size() == 0) chk("ovr_unexpected", ovr_q.size(), 1);
                else chk("ovr_time", cyc, ovr_q.pop_front());
            end else if (ovr_q.size() > 0 && ovr_q[0] <= cyc) begin
                chk("ovr_missing", overrun_tick, 1);
                void'(ovr_q.pop_front());
            end
            if (value_valid) begin
                if (val_q.size() == 0) begin
                    chk("valid_unexpected", value_valid, 0);
                end else begin
                    if (!prev_valid || prev_ready) chk("valid_latency", cyc, val_q[0].c);
                    chk("value", value, val_q[0].v);
                    if (value_ready) void'(val_q.pop_front());
                end
            end else if (val_q.size() > 0 && val_q[0].c <= cyc) begin
                chk("valid_missing", value_valid, 1);
                void'(val_q.pop_front());
            end
            prev_valid = value_valid;
            prev_ready = value_ready;
        end else begin
            prev_valid = 0;
            prev_ready = 0;
        end
    end

    logic [7:0] b;
    int         k;

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_zero("reset_init");
        rst_n = 1'b1;
        idle(1);

        line("1A3F", 1);
        send_str("ff", 1); send(8'h0D, 1); idle(1); send(8'h0A, 1); idle(1); idle(1);
        line("12G4", 1);
        line("5", 1);
        line("12345", 1);
        line("BEEF", 1);

        // Backpressure: '8' must be dropped; '9' rides in with the handshake.
        send_str("7", 0); send(8'h0D, 0); idle(0); idle(0);
        send("8", 0); idle(0); idle(0);
        send("9", 1); idle(1);
        send(8'h0D, 1); idle(1); idle(1); idle(1);

        // Reset mid-line discards the partial "12".
        send_str("12", 1);
        @(posedge clk); #1;
        rst_n = 1'b0; rx_done_tick = 1'b0;
        #1 chk_zero("reset_async");
        dig_q.delete(); m_bad = 0; m_hold = 0;
        repeat (3) begin @(negedge clk); chk_zero("reset_hold"); end
        @(posedge clk); #1 rst_n = 1'b1;
        line("5", 1);

        for (int n = 0; n < 600; n++) begin
            k = $urandom_range(0, 99);
            if (k < 60) begin
                b = "0" + 8'($urandom_range(0, 9));
                if ($urandom_range(0, 1) == 1)
                    b = ($urandom_range(0, 1) == 1) ? "A" + 8'($urandom_range(0, 5))
                                                    : "a" + 8'($urandom_range(0, 5));
            end else if (k < 85) begin
                b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'h0D;
            end else begin
                b = 8'($urandom_range(0, 255));
                while ((b >= "0" && b <= "9") || (b >= "A" && b <= "F") ||
                       (b >= "a" && b <= "f") || b == 8'h0D || b == 8'h0A)
                    b = 8'($urandom_range(0, 255));
            end
            send(b, $urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 2)) idle($urandom_range(0, 3) != 0);
        end

        repeat (10) idle(1);
        chk("val_q_drained", val_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);
        chk("ovr_q_drained", ovr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
